// File: rtl/word_store_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_store_buffer_if : core-side store request plus byte-wide MMU write port
// Revision: 1.0
// ---------------------------------------------------------------------------
interface word_store_buffer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0]    data;
    logic [1:0]               size;
    logic                     startStoring;
    logic                     ramBusy;
    logic                     busy;
    logic                     done;
    logic [ADDRESS_WIDTH-1:0] ramAddress;
    logic [7:0]               ramData;
    logic                     ramWriteEnable;
    logic                     ramRequest;

    modport master (
        output address, data, size, startStoring, ramBusy,
        input  busy, done, ramAddress, ramData, ramWriteEnable, ramRequest
    );

    modport slave (
        input  address, data, size, startStoring, ramBusy,
        output busy, done, ramAddress, ramData, ramWriteEnable, ramRequest
    );
endinterface
`default_nettype wire

// File: rtl/word_store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_store_buffer : serialises a byte/halfword/word store into MMU byte writes
// Revision: 1.0
// ---------------------------------------------------------------------------
module word_store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    word_store_buffer_if.slave bus
);
    localparam int N     = WORD_WIDTH / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [WORD_WIDTH-1:0]    data_q, data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     req_q, req_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               rdata_q, rdata_d;

    logic [IDX_W-1:0]         w_size_last;
    logic [WORD_WIDTH-1:0]    w_shifted;

    // Data is kept as a shift register so the next byte is always the low byte.
    assign w_shifted = data_q >> 8;

    always_comb begin
        w_size_last = IDX_W'(N - 1);
        case (bus.size)
            2'b00:   w_size_last = '0;
            2'b01:   w_size_last = (N > 1) ? IDX_W'(1) : '0;
            default: w_size_last = IDX_W'(N - 1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        req_d   = req_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.startStoring) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    last_d  = w_size_last;
                    data_d  = bus.data;
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    addr_d  = bus.address;
                    rdata_d = bus.data[7:0];
                end
            end
            ISSUE: begin
                if (bus.ramBusy) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (!bus.ramBusy) begin
                    if (idx_q == last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                        data_d  = w_shifted;
                        rdata_d = w_shifted[7:0];
                        addr_d  = addr_q + ADDRESS_WIDTH'(1);
                        req_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ramRequest     = req_q;
    assign bus.ramWriteEnable = req_q;
    assign bus.ramAddress     = addr_q;
    assign bus.ramData        = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_word_store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_word_store_buffer : randomized stores against a byte-list model and an MMU model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_word_store_buffer;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int   mmu_delay = 0;
    int   mmu_hold  = 1;
    logic [39:0] wlog[$];

    word_store_buffer_if #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32)) bus ();

    word_store_buffer #(.ADDRESS_WIDTH(32), .WORD_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MMU: registered responder; waits mmu_delay extra cycles, then holds ramBusy mmu_hold edges.
    initial begin
        int          mphase;
        int          mcnt;
        logic [31:0] cap_a;
        logic [7:0]  cap_d;
        mphase      = 0;
        mcnt        = 0;
        cap_a       = '0;
        cap_d       = '0;
        bus.ramBusy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                bus.ramBusy = 1'b0;
                mphase      = 0;
            end else begin
                case (mphase)
                    0: if (bus.ramRequest) begin
                        check_val("we_with_req", bus.ramWriteEnable, 1);
                        cap_a  = bus.ramAddress;
                        cap_d  = bus.ramData;
                        mcnt   = mmu_delay;
                        mphase = 1;
                    end
                    1: begin
                        check_val("req_hold", {bus.ramRequest, bus.ramAddress, bus.ramData}, {1'b1, cap_a, cap_d});
                        if (mcnt == 0) begin
                            wlog.push_back({cap_a, cap_d});
                            bus.ramBusy = 1'b1;
                            mcnt        = mmu_hold - 1;
                            mphase      = 2;
                        end else begin
                            mcnt--;
                        end
                    end
                    default: begin
                        check_val("wait_hold", {bus.ramRequest, bus.ramAddress, bus.ramData}, {1'b0, cap_a, cap_d});
                        if (mcnt == 0) begin
                            bus.ramBusy = 1'b0;
                            mphase      = 0;
                        end else begin
                            mcnt--;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [43:0] outs();
        return {bus.busy, bus.done, bus.ramRequest, bus.ramWriteEnable, bus.ramAddress, bus.ramData};
    endfunction

    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input int dly, input int hld, input bit intrude);
        logic [39:0] exp_q[$];
        logic [31:0] ea;
        logic [7:0]  eb;
        int          cnt;
        int          start_cyc;
        int          guard;
        bit          seen_done;
        bit          stray;
        cnt = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < cnt; i++) begin
            ea = a + 32'(i);
            eb = 8'(d >> (8 * i));
            exp_q.push_back({ea, eb});
        end
        mmu_delay = dly;
        mmu_hold  = hld;
        wlog.delete();
        @(negedge clk);
        bus.address      = a;
        bus.data         = d;
        bus.size         = sz;
        bus.startStoring = 1'b1;
        @(negedge clk);
        bus.startStoring = 1'b0;
        start_cyc        = cyc;
        check_val("start_busy", bus.busy, 1);
        check_val("start_req", {bus.ramRequest, bus.ramWriteEnable}, 2'b11);
        check_val("first_addr", bus.ramAddress, a);
        check_val("first_data", bus.ramData, d[7:0]);
        seen_done = 1'b0;
        guard     = 0;
        while (!seen_done && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (intrude && (cyc - start_cyc) == 2) begin
                bus.startStoring = 1'b1;
                bus.data         = 32'h1111_1111;
            end else if (intrude && (cyc - start_cyc) == 6) begin
                bus.startStoring = 1'b0;
            end
            if (bus.done) seen_done = 1'b1;
        end
        bus.startStoring = 1'b0;
        check_val("done_seen", seen_done, 1);
        check_val("latency", cyc - start_cyc, cnt * (dly + hld + 2));
        check_val("busy_at_done", bus.busy, 0);
        check_val("write_count", wlog.size(), cnt);
        for (int i = 0; i < cnt && i < wlog.size(); i++)
            check_val("write_addr_data", wlog[i], exp_q[i]);
        @(negedge clk);
        check_val("done_one_cycle", bus.done, 0);
        stray = 1'b0;
        repeat (4) begin
            if (bus.ramRequest) stray = 1'b1;
            @(negedge clk);
        end
        check_val("no_stray_req", stray, 0);
        check_val("write_count_after", wlog.size(), cnt);
    endtask

    initial begin
        int guard;
        logic [31:0] ra;
        reset            = 1'b0;
        bus.address      = '0;
        bus.data         = '0;
        bus.size         = '0;
        bus.startStoring = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_state", outs(), 44'h0);
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_after_reset", outs(), 44'h0);

        run_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 2, 1'b0);
        run_store(32'h0000_0020, 32'h1234_5678, 2'b00, 0, 1, 1'b0);
        run_store(32'hFFFF_FFFF, 32'h0000_ABCD, 2'b01, 0, 1, 1'b0);
        run_store(32'h0000_0300, 32'h0BAD_F00D, 2'b10, 0, 1, 1'b0);
        run_store(32'h0000_0400, 32'hA1B2_C3D4, 2'b10, 4, 10, 1'b0);
        run_store(32'h0000_0040, 32'hCAFE_BABE, 2'b10, 0, 1, 1'b1);
        run_store(32'h0000_0051, 32'h7766_5544, 2'b11, 1, 1, 1'b0);

        // Reset in the middle of the second byte of a word store.
        mmu_delay = 1;
        mmu_hold  = 2;
        wlog.delete();
        @(negedge clk);
        bus.address      = 32'h0000_0200;
        bus.data         = 32'h55AA_33CC;
        bus.size         = 2'b10;
        bus.startStoring = 1'b1;
        @(negedge clk);
        bus.startStoring = 1'b0;
        guard = 0;
        while (!(wlog.size() == 1 && bus.ramRequest) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("reach_byte2", wlog.size(), 1);
        #2;
        reset = 1'b0;
        #1;
        check_val("reset_async_outs", outs(), 44'h0);
        repeat (4) @(negedge clk);
        check_val("reset_held_outs", outs(), 44'h0);
        check_val("reset_no_writes", wlog.size(), 1);
        reset = 1'b1;
        run_store(32'h0000_0600, 32'h0102_0304, 2'b10, 0, 1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom();
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            run_store(ra, $urandom(), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/word_store_buffer.md
# word_store_buffer

Write-side counterpart of the opcode buffer: accepts a store of a byte, halfword or word from the core and serialises it into byte writes on the byte-wide MMU port. It sits between the execute stage and the MMU's write interface (`writeEnable`, `dataIn`, `request`, `busy`). It holds `busy` until the last byte has been accepted and completed by the MMU.

## Interface
- `ADDRESS_WIDTH`, 32, width of byte addresses.
- `WORD_WIDTH`, 32, width of store data. Must be a multiple of 8. Byte count `N = WORD_WIDTH/8`.

- `clk`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. `reset == 0` forces reset state immediately.
- `address`  in  ADDRESS_WIDTH  byte address of the store. Sampled on accepted start.
- `data`  in  WORD_WIDTH  store data, least significant byte first. Sampled on accepted start.
- `size`  in  2  `00` byte, `01` halfword, `10` word. `11` is treated as word. Sampled on accepted start.
- `startStoring`  in  1  store request. Accepted only when `busy == 0`.
- `ramBusy`  in  1  MMU busy flag.
- `busy`  out  1  store in progress.
- `done`  out  1  one-cycle pulse when the store completes.
- `ramAddress`  out  ADDRESS_WIDTH  byte address to the MMU.
- `ramData`  out  8  byte to the MMU.
- `ramWriteEnable`  out  1  write strobe to the MMU.
- `ramRequest`  out  1  request strobe to the MMU.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - On an edge with `startStoring == 1`:
    - latch `address`, `data` and byte count (`size` 00 -> 1, 01 -> 2, else N);
    - clear byte index `i`;
    - set `busy`;
    - go to ISSUE.
- **ISSUE**
  - Drive `ramRequest = ramWriteEnable = 1`, `ramAddress = addr + i`, `ramData = data[8i+7:8i]`.
  - The MMU acknowledges by raising `ramBusy`.
  - On an edge with `ramBusy == 1`: go to WAIT, drop `ramRequest` and `ramWriteEnable`.
  - Otherwise hold all outputs.
- **WAIT**
  - Hold `ramAddress` and `ramData`.
  - On an edge with `ramBusy == 0`:
    - if `i == count-1`: clear `busy`, pulse `done`, go to IDLE;
    - else: `i <= i+1`, go to ISSUE.
- Byte order is little-endian: byte `i` goes to `addr + i`.
- Address arithmetic is modulo 2^ADDRESS_WIDTH, so addresses wrap past all-ones to 0.
- `startStoring` while `busy == 1` is ignored. It is not queued.
- No alignment check: unaligned halfword and word stores are performed byte-wise.
- Reset, including mid-operation:
  - all outputs go to 0 and the state goes to IDLE;
  - bytes already written remain in memory, and there is no rollback.

## Timing
- Reset values: `busy = 0`, `done = 0`, `ramRequest = 0`, `ramWriteEnable = 0`, `ramAddress = 0`, `ramData = 0`. State IDLE, `i = 0`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Start accepted at edge T:
  - `busy`, `ramRequest`, `ramWriteEnable` and the first byte are valid after T;
  - start-to-request latency is 1 cycle.
- Per byte, if the MMU raises `ramBusy` at edge A and holds it for k ≥ 1 edges: the byte costs (A - issue edge) + k + 1 cycles.
  - Minimum 3 cycles per byte.
  - A word store with k = 1 completes in 12 cycles after start.
- `done` is high exactly one cycle, coincident with the first cycle of `busy == 0`.
- A new start is accepted on the edge after `done` rises, i.e. the first edge seen with `busy == 0`.
- `ramAddress` and `ramData` are stable from request until the byte's WAIT exits.

## Test plan
- Word store `address = 0x100`, `data = 0xDEADBEEF`, `size = 10`, MMU busy for 2 cycles per access.
  - Required: writes EF@0x100, BE@0x101, AD@0x102, DE@0x103 in order.
  - Required: `done` pulses once and `busy` falls with it.
- Byte store `address = 0x20`, `data = 0x12345678`, `size = 00`.
  - Required: a single write of 0x78@0x20 and no further requests.
- Halfword store `address = 0xFFFFFFFF`, `data = 0x0000ABCD`, `size = 01`.
  - Required: CD@0xFFFFFFFF, then AB@0x00000000.
- Long MMU stall: `ramBusy` held low for 5 cycles after the request, then high for 10 cycles.
  - Required: `ramRequest`, `ramAddress` and `ramData` hold their values throughout; each byte is written exactly once.
- A second `startStoring` (`data = 0x11111111`) is asserted mid-store of 0xCAFEBABE@0x40.
  - Required: memory receives only 0xCAFEBABE; no second store follows `done`.
- `reset` pulled low during the second byte of a word store.
  - Required: all outputs are 0 immediately, with no further writes.
  - Required: a new store after `reset` goes high completes normally.
